// File: rtl/vga_timing_pkg.sv
// Shared raster constants for 640x480@60 and the screen geometry the renderers draw against.
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef struct packed {
    logic [9:0] width;
    logic [9:0] height;
  } screen_geom_t;

  localparam screen_geom_t SCREEN_GEOM = '{width: 10'(H_VISIBLE_DEF), height: 10'(V_VISIBLE_DEF)};

  function automatic logic in_range(input logic [9:0] x, input logic [9:0] lo, input logic [9:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/pixel_clk_en.sv
// Divide-by-CLK_DIV pixel enable: a registered one-clk pulse while div_cnt sits at CLK_DIV-1.
module pixel_clk_en #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_en_q, pix_en_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    // Look at the next count so the pulse lines up with the clk where div_cnt is last.
    pix_en_d  = (div_cnt_d == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      pix_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= pix_en_d;
    end
  end

  assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters plus sync/vidon/frame_tick decode, all registered from next-state counters.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV     = 4,
  parameter int   H_VISIBLE   = int'(SCREEN_GEOM.width),
  parameter int   H_FP        = H_FP_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BP        = H_BP_DEF,
  parameter int   V_VISIBLE   = int'(SCREEN_GEOM.height),
  parameter int   V_FP        = V_FP_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BP        = V_BP_DEF,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_counter,
  output logic [9:0] v_counter,
  output logic       vidon,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_en,
  output logic       frame_tick
);

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic       pix_en_w;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       vidon_q, vidon_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_tick_q, frame_tick_d;

  pixel_clk_en #(.CLK_DIV(CLK_DIV)) u_pixel_clk_en (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en_w)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en_w) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    vidon_d      = (h_d < H_VIS) && (v_d < V_VIS);
    hsync_d      = in_range(h_d, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d      = in_range(v_d, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    // Qualified by pix_en so the pulse covers only the first clk of (0, V_VISIBLE).
    frame_tick_d = pix_en_w && (h_d == '0) && (v_d == V_VIS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q          <= '0;
      v_q          <= '0;
      vidon_q      <= 1'b0;
      hsync_q      <= ~SYNC_ACTIVE;
      vsync_q      <= ~SYNC_ACTIVE;
      frame_tick_q <= 1'b0;
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      vidon_q      <= vidon_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign h_counter  = h_q;
  assign v_counter  = v_q;
  assign vidon      = vidon_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign pix_en     = pix_en_w;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance (a) and a CLK_DIV=1, 12-line-frame instance (b).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic [9:0] a_h, a_v, b_h, b_v;
  logic a_vidon, a_hs, a_vs, a_pix, a_tick;
  logic b_vidon, b_hs, b_vs, b_pix, b_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_a), .h_counter(a_h), .v_counter(a_v), .vidon(a_vidon),
    .hsync(a_hs), .vsync(a_vs), .pix_en(a_pix), .frame_tick(a_tick)
  );

  // Full-width lines, but only 12 lines per frame (vsync on lines 8..9) to keep frames short.
  vga_timing_gen #(
    .CLK_DIV(1), .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .h_counter(b_h), .v_counter(b_v), .vidon(b_vidon),
    .hsync(b_hs), .vsync(b_vs), .pix_en(b_pix), .frame_tick(b_tick)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int pcnt, hs_low, vid_cnt, mis, ticks, n, nlow, vs_low, vid_bad, first_tick;
    int tick_k[4];

    // ---- reset values ----
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_h", 32'(a_h), 0);
    chk("rst_v", 32'(a_v), 0);
    chk("rst_vidon", 32'(a_vidon), 0);
    chk("rst_hsync", 32'(a_hs), 1);
    chk("rst_vsync", 32'(a_vs), 1);
    chk("rst_pix_en", 32'(a_pix), 0);
    chk("rst_frame_tick", 32'(a_tick), 0);
    $display("step: reset values checked");

    // ---- instance a: two lines from release ----
    pcnt = 0; hs_low = 0; vid_cnt = 0; mis = 0; ticks = 0;
    rst_a = 1'b1;
    for (int k = 1; k <= 6400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("rel_vidon", 32'(a_vidon), 1);
        chk("rel_h", 32'(a_h), 0);
      end
      if (k == 3) begin
        chk("first_pix_en", 32'(a_pix), 1);
        chk("h_before_adv", 32'(a_h), 0);
      end
      if (k == 4) begin
        chk("h_after_adv", 32'(a_h), 1);
        chk("v_after_adv", 32'(a_v), 0);
      end
      if (k == 3199) chk("h_last", 32'({a_v, a_h}), 32'({10'd0, 10'd799}));
      if (k == 3200) chk("line_wrap", 32'({a_v, a_h}), 32'({10'd1, 10'd0}));
      if (k <= 3200 && a_pix) pcnt++;
      if (k >= 3200 && k < 6400) begin
        if (!a_hs) hs_low++;
        if (a_vidon) vid_cnt++;
      end
      if (a_vidon !== ((a_h < 10'd640) && (a_v < 10'd480))) mis++;
      if (a_hs !== !((a_h >= 10'd656) && (a_h <= 10'd751))) mis++;
      if (a_vs !== !((a_v >= 10'd490) && (a_v <= 10'd491))) mis++;
      if (a_tick) ticks++;
    end
    chk("a_pix_en_count", 32'(pcnt), 800);
    chk("a_hsync_low_clks", 32'(hs_low), 384);
    chk("a_vidon_clks", 32'(vid_cnt), 2560);
    chk("a_decode_align", 32'(mis), 0);
    chk("a_no_tick", 32'(ticks), 0);
    chk("a_line2", 32'({a_v, a_h}), 32'({10'd2, 10'd0}));
    $display("step: instance a two lines, pix_en=%0d hsync_low=%0d vidon=%0d", pcnt, hs_low, vid_cnt);

    // ---- instance a: reset mid-line ----
    n = 0;
    while (a_h != 10'd300 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("a_reach_h300", 32'(a_h), 300);
    rst_a = 1'b0;
    #1;
    chk("mid_rst_counters", 32'({a_v, a_h}), 0);
    chk("mid_rst_vidon", 32'(a_vidon), 0);
    chk("mid_rst_sync", 32'({a_hs, a_vs}), 3);
    chk("mid_rst_pix_tick", 32'({a_pix, a_tick}), 0);
    repeat (7) @(negedge clk);
    chk("mid_rst_hold", 32'({a_v, a_h, a_vidon, a_pix, a_tick}), 0);
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("rerel_h_e3", 32'(a_h), 0);
    @(negedge clk);
    chk("rerel_counters_e4", 32'({a_v, a_h}), 32'({10'd0, 10'd1}));
    ticks = 0;
    repeat (2000) begin
      @(negedge clk);
      if (a_tick) ticks++;
    end
    chk("rerel_no_tick", 32'(ticks), 0);
    $display("step: instance a mid-frame reset checked");

    // ---- instance b: CLK_DIV=1, three short frames ----
    nlow = 0; hs_low = 0; vs_low = 0; vid_bad = 0; mis = 0; ticks = 0;
    for (int i = 0; i < 4; i++) tick_k[i] = 0;
    rst_b = 1'b1;
    for (int k = 1; k <= 28000; k++) begin
      @(negedge clk);
      if (!b_pix) nlow++;
      if (k == 800) chk("b_h_last", 32'({b_v, b_h}), 32'({10'd0, 10'd799}));
      if (k == 801) chk("b_line_wrap", 32'({b_v, b_h}), 32'({10'd1, 10'd0}));
      if (k == 9600) chk("b_frame_last", 32'({b_v, b_h}), 32'({10'd11, 10'd799}));
      if (k == 9601) chk("b_frame_wrap", 32'({b_v, b_h}), 0);
      if (k >= 801 && k <= 1600 && !b_hs) hs_low++;
      if (k <= 9600 && !b_vs) vs_low++;
      if (b_vidon && b_v >= 10'd6) vid_bad++;
      if (b_vidon !== ((b_h < 10'd640) && (b_v < 10'd6))) mis++;
      if (b_hs !== !((b_h >= 10'd656) && (b_h <= 10'd751))) mis++;
      if (b_vs !== !((b_v >= 10'd8) && (b_v <= 10'd9))) mis++;
      if (b_tick) begin
        chk("b_tick_pos", 32'({b_v, b_h}), 32'({10'd6, 10'd0}));
        if (ticks < 4) tick_k[ticks] = k;
        ticks++;
      end
    end
    chk("b_pix_en_const", 32'(nlow), 0);
    chk("b_hsync_low_clks", 32'(hs_low), 96);
    chk("b_vsync_low_clks", 32'(vs_low), 1600);
    chk("b_vidon_in_vblank", 32'(vid_bad), 0);
    chk("b_decode_align", 32'(mis), 0);
    chk("b_tick_count", 32'(ticks), 3);
    chk("b_tick0_clk", 32'(tick_k[0]), 4801);
    chk("b_tick_spacing1", 32'(tick_k[1] - tick_k[0]), 9600);
    chk("b_tick_spacing2", 32'(tick_k[2] - tick_k[1]), 9600);
    $display("step: instance b three frames, ticks=%0d first=%0d", ticks, tick_k[0]);

    // ---- instance b: reset mid-frame, next tick only on reaching line 6 ----
    n = 0;
    while (!(b_v == 10'd3 && b_h == 10'd300) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("b_reach_v3_h300", 32'({b_v, b_h}), 32'({10'd3, 10'd300}));
    rst_b = 1'b0;
    #1;
    chk("b_mid_rst", 32'({b_v, b_h, b_vidon, b_hs, b_vs, b_pix, b_tick}), 32'b1100);
    repeat (7) @(negedge clk);
    rst_b = 1'b1;
    ticks = 0; first_tick = 0;
    for (int k = 1; k <= 5000; k++) begin
      @(negedge clk);
      if (k == 2) chk("b_rerel_counters", 32'({b_v, b_h}), 32'({10'd0, 10'd1}));
      if (b_tick) begin
        if (ticks == 0) first_tick = k;
        ticks++;
      end
    end
    chk("b_rerel_tick_count", 32'(ticks), 1);
    chk("b_rerel_tick_clk", 32'(first_tick), 4801);
    $display("step: instance b mid-frame reset, tick at %0d", first_tick);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
